// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage types and constants for instr_fetch_queue.
// Holds the FSM encoding, FIFO entry layout and PC helpers.
package instr_fetch_queue_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_RUN   = 2'd1,
    FS_FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous DEPTH x {pc,instr} FIFO for the fetch queue.
// Clear wins over push/pop; push+pop on a full FIFO is legal.
module instr_fetch_queue_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [63:0]   din,
  input  logic          pop,
  output logic [63:0]   dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = fetch_entry_t'(din);
        wr_d        = wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC, credit-limited imem requests, FIFO to decode, redirect flush.
// Define FETCH_BYPASS_EN for a zero-latency imem response -> decode path.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus_four
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] credits;
  logic [63:0]   fifo_dout;
  logic [31:0]   redir_al;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          req_fire;
  logic          rsp_live;
  logic          byp;
  fetch_entry_t  head;

  assign redir_al = word_align(redirect_pc);
  assign credits  = outst_q + fifo_count;

  assign imem_req_valid = (state_q == FS_RUN) && !redirect_valid
                       && (credits < CW'(DEPTH)) && !fifo_full;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are only kept in RUN; discard>0 always means FLUSH.
  assign rsp_live = imem_rsp_valid && (state_q == FS_RUN)
                 && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign byp = rsp_live && fifo_empty;
`else
  assign byp = 1'b0;
`endif

  assign head = byp ? fetch_entry_t'{pc: rsp_pc_q, instr: imem_rsp_data}
                    : fetch_entry_t'(fifo_dout);

  assign dec_valid        = !fifo_empty || byp;
  assign dec_instr        = dec_valid ? head.instr : '0;
  assign dec_pc           = dec_valid ? head.pc : '0;
  assign dec_pc_plus_four = dec_valid ? head.pc + PC_INC : '0;

  assign fifo_pop  = !fifo_empty && dec_ready;
  assign fifo_push = rsp_live && !(byp && dec_ready);

  instr_fetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect_valid),
    .push  (fifo_push),
    .din   ({rsp_pc_q, imem_rsp_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_d     = disc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    // rsp_pc tracks the address of the next live response in order.
    if (redirect_valid) begin
      fetch_pc_d = redir_al;
      rsp_pc_d   = redir_al;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
      if (rsp_live) rsp_pc_d   = rsp_pc_q + PC_INC;
    end
    unique case (state_q)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN: begin
        if (redirect_valid) begin
          disc_d = outst_q - CW'(imem_rsp_valid);
          if (disc_d != '0) state_d = FS_FLUSH;
        end
      end
      FS_FLUSH: begin
        disc_d = disc_q - CW'(imem_rsp_valid);
        if (disc_d == '0) state_d = FS_RUN;
      end
      default: state_d = FS_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: stall table, corner
// sequences and random traffic against a queue-based memory/stream model.
module tb_instr_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus_four;

  instr_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_addr    (imem_req_addr),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .dec_valid        (dec_valid),
    .dec_ready        (dec_ready),
    .dec_instr        (dec_instr),
    .dec_pc           (dec_pc),
    .dec_pc_plus_four (dec_pc_plus_four)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } pend_t;

  typedef struct {
    logic [31:0] tgt;
    int          lat;
    int          exp_reqs;
    logic [31:0] exp_pc;
    logic [31:0] exp_last;
  } vec_t;

  pend_t       pend[$];
  int          cyc, epoch, acc_cur, con_cur;
  int          nchk, nerr, nreq, ndec;
  int          lat_fix;
  bit          rnd_ready, fired, want_first;
  logic [31:0] exp_req, exp_dec, last_req, first_pc;
  logic        s_dv, s_rv;
  logic [31:0] s_pc;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int live_pend();
    int n = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) n++;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rdy, input int rmode,
                      input logic [31:0] tgt);
    int          q, old;
    bit          rsp_cur, redir;
    q       = 0;
    rsp_cur = 1'b0;
    @(negedge clk);
    q = acc_cur - con_cur - live_pend();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend[0].addr);
      rsp_cur        = (pend[0].ep == epoch);
      void'(pend.pop_front());
    end
    imem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    dec_ready      = rdy;
    redirect_valid = (rmode == 1);
    redirect_pc    = tgt;
    #1;
    if (rmode == 2 && imem_rsp_valid && dec_valid && q > 0
        && pend.size() > 0) begin
      redirect_valid = 1'b1;
      fired          = 1'b1;
      #1;
    end
    redir = redirect_valid;
    old   = pend.size() - live_pend();
    s_dv  = dec_valid;
    s_rv  = imem_req_valid;
    s_pc  = dec_pc;
    chk("dec_valid", 32'(dec_valid),
        32'((q > 0) || (BYP && rsp_cur && !redir)));
    chk("req_in_redirect", 32'(imem_req_valid && redir), 0);
    chk("req_during_flush", 32'(imem_req_valid && old > 0), 0);
    chk("credit", 32'(imem_req_valid &&
        (pend.size() + 32'(imem_rsp_valid) + q >= DEPTH)), 0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req);
      pend.push_back('{addr: imem_req_addr,
                       due: cyc + (lat_fix > 0 ? lat_fix
                                   : int'($urandom_range(1, 4))),
                       ep: epoch});
      last_req = imem_req_addr;
      exp_req  = exp_req + 32'd4;
      acc_cur++;
      nreq++;
    end
    if (dec_valid && dec_ready) begin
      chk("dec_pc", dec_pc, exp_dec);
      chk("dec_instr", dec_instr, word_of(exp_dec));
      chk("dec_pc_plus_four", dec_pc_plus_four, exp_dec + 32'd4);
      if (want_first) begin
        first_pc   = dec_pc;
        want_first = 1'b0;
      end
      exp_dec = exp_dec + 32'd4;
      con_cur++;
      ndec++;
    end
    if (redir) begin
      epoch++;
      acc_cur    = 0;
      con_cur    = 0;
      exp_req    = {tgt[31:2], 2'b00};
      exp_dec    = {tgt[31:2], 2'b00};
      want_first = 1'b1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    pend.delete();
    epoch++;
    acc_cur = 0;
    con_cur = 0;
    exp_req = 32'h0;
    exp_dec = 32'h0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_pc4", dec_pc_plus_four, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_no_req", 32'(imem_req_valid), 0);
    @(posedge clk);
    cyc++;
  endtask

  vec_t vecs[4];

  initial begin
    int base;
    bit r;
    vecs[0] = '{32'h0000_0100, 1, 4, 32'h0000_0100, 32'h0000_010C};
    vecs[1] = '{32'h0000_0203, 3, 4, 32'h0000_0200, 32'h0000_020C};
    vecs[2] = '{32'hFFFF_FFF8, 2, 4, 32'hFFFF_FFF8, 32'h0000_0004};
    vecs[3] = '{32'h8000_0001, 4, 4, 32'h8000_0000, 32'h8000_000C};
    nchk = 0; nerr = 0; nreq = 0; ndec = 0; cyc = 0; epoch = 0;
    fired = 0; want_first = 0; first_pc = '0; last_req = '0;
    reset = 1'b0; redirect_pc = '0;
    do_reset();

    lat_fix = 1; rnd_ready = 0;
    for (int i = 0; i < 30; i++) step(1'b1, 0, '0);
    chk("stream_progress", 32'(ndec >= 20), 1);

    foreach (vecs[k]) begin
      lat_fix = vecs[k].lat;
      step(1'b0, 1, vecs[k].tgt);
      base = nreq;
      for (int c = 0; c < 24; c++) begin
        step(1'b0, 0, '0);
        if (s_dv) chk("hold_pc", s_pc, vecs[k].exp_pc);
      end
      chk("stall_reqs", 32'(nreq - base), 32'(vecs[k].exp_reqs));
      chk("stall_dv", 32'(s_dv), 1);
      chk("stall_dec_pc", s_pc, vecs[k].exp_pc);
      chk("stall_req_valid", 32'(s_rv), 0);
      chk("stall_last_req", last_req, vecs[k].exp_last);
      for (int c = 0; c < 20; c++) step(1'b1, 0, '0);
    end

    lat_fix = 3;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() == 2 && live_pend() == 2) break;
      step(1'b1, 0, '0);
    end
    chk("two_in_flight", 32'(pend.size()), 2);
    step(1'b1, 1, 32'h0000_0103);
    for (int i = 0; i < 16; i++) step(1'b1, 0, '0);
    chk("redir_first_pc", first_pc, 32'h0000_0100);

    lat_fix = 2; fired = 0;
    for (int i = 0; i < 60 && !fired; i++) begin
      r = 1'($urandom_range(0, 1));
      step(r, 2, 32'h0000_0300);
    end
    chk("coincide_fired", 32'(fired), 1);
    step(1'b1, 0, '0);
    chk("coincide_dv_next", 32'(s_dv), 0);
    chk("coincide_flush_req", 32'(s_rv), 0);
    for (int i = 0; i < 16; i++) step(1'b1, 0, '0);
    chk("coincide_first_pc", first_pc, 32'h0000_0300);

    lat_fix = 0; rnd_ready = 1;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 3) != 0);
      step(r, ($urandom_range(0, 39) == 0) ? 1 : 0, $urandom);
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 3) != 0);
      step(r, ($urandom_range(0, 39) == 0) ? 1 : 0, $urandom);
    end
    chk("random_progress", 32'(ndec > 500), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
